xor_issue_collector: RTL

// - Initiator/consumer for a fixed-latency XOR functional unit in the CVXIF example coprocessor.
// - Accepts issue requests (id, rs1, rs2) on a valid/ready handshake and drives the operands to the unit.
// - Tags each request through a LATENCY-deep pipe and captures the unit's result on arrival.
// - Returns {id, data} on a valid/ready result handshake, buffered in a credit-protected FIFO.

---
 rtl/xor_issue_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/xor_issue_collector.sv
// xor_issue_collector: issue/result collector for a fixed-latency XOR unit.
// Tags each accepted request through a LATENCY-deep pipe, captures the unit
// result when the tag arrives and buffers {id, data} in a credit-protected
// FIFO. Define XOR_COLLECTOR_BYPASS_EN to let a result skip an empty FIFO
// when the consumer is ready in the capture cycle.
module xor_issue_collector #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         kill_i,
    input  logic                                         issue_valid_i,
    output logic                                         issue_ready_o,
    input  logic [ID_WIDTH-1:0]                          issue_id_i,
    input  logic [31:0]                                  issue_rs1_i,
    input  logic [31:0]                                  issue_rs2_i,
    output logic [31:0]                                  fu_rs1_o,
    output logic [31:0]                                  fu_rs2_o,
    input  logic [31:0]                                  fu_result_i,
    output logic                                         result_valid_o,
    input  logic                                         result_ready_i,
    output logic [ID_WIDTH-1:0]                          result_id_o,
    output logic [31:0]                                  result_data_o,
    output logic [$clog2(LATENCY+FIFO_DEPTH+1)-1:0]      inflight_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W  = $clog2(LATENCY + FIFO_DEPTH + 1);

    logic [LATENCY-1:0]               tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0][ID_WIDTH-1:0] tag_id_q, tag_id_d;
    logic [ID_WIDTH-1:0]              mem_id_q   [FIFO_DEPTH];
    logic [DATA_W-1:0]                mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]                 inflight_q, inflight_d;
    logic [ID_WIDTH-1:0]              hold_id_q, hold_id_d;
    logic [DATA_W-1:0]                hold_data_q, hold_data_d;

    logic                fire;
    logic                last_vld;
    logic [ID_WIDTH-1:0] last_id;
    logic                fifo_empty;
    logic                bypass;
    logic                pop;
    logic                fifo_pop;
    logic                push;

    // Handshake decode, credit check and result presentation
    always_comb begin
        issue_ready_o = !kill_i && (inflight_q < CNT_W'(FIFO_DEPTH));
        fire          = issue_valid_i && issue_ready_o;
        fu_rs1_o      = fire ? issue_rs1_i : '0;
        fu_rs2_o      = fire ? issue_rs2_i : '0;
        last_vld      = tag_vld_q[LATENCY-1];
        last_id       = tag_id_q[LATENCY-1];
        fifo_empty    = (cnt_q == '0);
`ifdef XOR_COLLECTOR_BYPASS_EN
        bypass        = fifo_empty && last_vld && result_ready_i && !kill_i;
`else
        bypass        = 1'b0;
`endif
        result_valid_o = !fifo_empty || bypass;
        if (!fifo_empty) begin
            result_id_o   = mem_id_q[rd_ptr_q];
            result_data_o = mem_data_q[rd_ptr_q];
        end else if (bypass) begin
            result_id_o   = last_id;
            result_data_o = fu_result_i;
        end else begin
            result_id_o   = hold_id_q;
            result_data_o = hold_data_q;
        end
        pop        = result_valid_o && result_ready_i && !kill_i;
        fifo_pop   = pop && !fifo_empty;
        push       = last_vld && !bypass && !kill_i;
        inflight_o = inflight_q;
    end

    // Next state for tag pipe, FIFO pointers, counters and held output
    always_comb begin
        tag_vld_d   = tag_vld_q;
        tag_id_d    = tag_id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        inflight_d  = inflight_q;
        hold_id_d   = result_valid_o ? result_id_o : hold_id_q;
        hold_data_d = result_valid_o ? result_data_o : hold_data_q;
        if (kill_i) begin
            tag_vld_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            inflight_d = '0;
        end else begin
            tag_vld_d[0] = fire;
            tag_id_d[0]  = issue_id_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !fifo_pop) begin
                cnt_d = cnt_q + FCNT_W'(1);
            end else if (!push && fifo_pop) begin
                cnt_d = cnt_q - FCNT_W'(1);
            end
            if (fire && !pop) begin
                inflight_d = inflight_q + CNT_W'(1);
            end else if (!fire && pop) begin
                inflight_d = inflight_q - CNT_W'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            inflight_q  <= '0;
            hold_id_q   <= '0;
            hold_data_q <= '0;
        end else begin
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            hold_id_q   <= hold_id_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Result storage; contents are only observed through valid entries
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_id_q[wr_ptr_q]   <= last_id;
            mem_data_q[wr_ptr_q] <= fu_result_i;
        end
    end

endmodule
